dsp48a1_post_adder: RTL and testbench
=====================================

// Module: dsp48a1_post_adder
// PURPOSE
//  Post-adder/accumulator stage of the Spartan-6 DSP48A1 slice model; consumes the M-stage output and the
//  D:A:B, C and PCIN operands after their pipeline registers.
//  Selects X/Z operands per OPMODE, adds or subtracts them with carry-in, and optionally registers P and CARRYOUT.
//  The registered P feeds back as the accumulator source and drives PCOUT to the next slice.
// PARAMETERS
//  PREG         1  1: P output registered (1-cycle latency); 0: P combinational
//  CARRYOUTREG  1  1: CARRYOUT/CARRYOUTF registered; 0: combinational
// PORTS
//  clk        in   1   single clock; all state updates on rising edge
//  rst        in   1   reset, synchronous, active-high; clears P and CARRYOUT registers; dominates ce_*
//  ce_p       in   1   clock enable, P register
//  ce_carry   in   1   clock enable, CARRYOUT register
//  opmode     in   8   [7]=0 add / 1 subtract; [3:2] Z select; [1:0] X select; other bits ignored here
//  m_in       in   36  multiplier product, two's complement
//  dab_in     in   48  concat {D[11:0],A[17:0],B[17:0]}
//  c_in       in   48  C operand
//  pcin       in   48  cascade input from previous slice
//  cin        in   1   carry-in, already selected/registered upstream
//  p          out  48  post-adder result
//  pcout      out  48  cascade output, always equal to p
//  carryout   out  1   carry/borrow out of bit 47
//  carryoutf  out  1   fabric copy of carryout, identical value and timing
// BEHAVIOUR
//  - X mux ([1:0]): 00 -> 48'd0; 01 -> sign-extended m_in; 10 -> P feedback; 11 -> dab_in.
//  - Z mux ([3:2]): 00 -> 48'd0; 01 -> pcin; 10 -> P feedback; 11 -> c_in.
//  - P feedback always taps the internal P register output, never the combinational sum.
//  - Arithmetic is 49-bit unsigned. Operands are zero-extended to 49 bits (X after the sign-extension above).
//      add: r = {1'b0,Z} + {1'b0,X} + cin
//      sub: r = {1'b0,Z} - ({1'b0,X} + cin)
//  - Results: sum = r[47:0]; co = r[48]. On subtract, co=1 means borrow.
//  - Width rule: P wraps modulo 2^48; there is no saturation.
//  - PREG=1: at each clk edge, rst -> p_reg=0; else ce_p -> p_reg=sum; else hold.
//    p = p_reg, so latency is 1 cycle from operands to p.
//  - PREG=0: p = sum in the same cycle. Selecting P feedback (X=10 or Z=10) is illegal:
//    the feedback term reads 0 and a simulation-only $error fires.
//  - CARRYOUTREG=1: same rst/ce rule with ce_carry, capturing co.
//    CARRYOUTREG=0: carryout = co, combinational.
//  - Reset values: p=0, pcout=0, carryout=0, carryoutf=0 (registered modes).
//    Reset is held while asserted and overrides ce_* and opmode.
//  - Reset mid-accumulation: the next edge loads 0. The first edge after rst drops accumulates from 0.
//  - Simultaneous ce_p=1 with ce_carry=0: P updates, carryout holds its stale value. This is legal and intended.
//  - opmode changes take effect on the operands of the same cycle; no opmode register lives in this block.
// STRUCTURE
//  - Shared package dsp48a1_pkg:
//      localparams X_ZERO/X_M/X_P/X_DAB and Z_ZERO/Z_PCIN/Z_P/Z_C (2-bit codes)
//      OPM_SUB_BIT=7, P_W=48, M_W=36
//  - One natural sub-module: dsp48a1_xz_mux (combinational X/Z selection, including M sign-extension).
//  - Adder, P register and CARRYOUT register live inline in this module.
// TESTING
//  1. PREG=1, X=01 Z=00 add, m_in=5, cin=0, ce_p=1 -> p=5 one edge later, carryout=0.
//  2. Accumulate: X=01 Z=10, m_in=3, 4 edges after rst -> p=3,6,9,12; pcout tracks p.
//  3. Sub: opmode[7]=1, Z=11 c_in=10, X=11 dab_in=3, cin=1 -> p=6, carryout=0;
//     then c_in=2 -> p=48'hFFFF_FFFF_FFFE, carryout=1.
//  4. Wrap: add, Z=11 c_in=48'hFFFF_FFFF_FFFF, X=11 dab_in=1, cin=0 -> p=0, carryout=carryoutf=1.
//  5. rst=1 with ce_p=1 during accumulation at p=9 -> p=0, carryout=0 next edge; after release, accumulation restarts from 3.
//  6. ce_p=0 while operands change -> p holds. PREG=0 build: p follows sum same cycle; X=10 fires $error.

Source files
------------

// File: rtl/dsp48a1_pkg.sv
// Shared constants and types for the DSP48A1 slice model.
package dsp48a1_pkg;

  localparam int P_W = 48;
  localparam int M_W = 36;
  localparam int OPM_SUB_BIT = 7;

  localparam logic [1:0] X_ZERO = 2'b00;
  localparam logic [1:0] X_M    = 2'b01;
  localparam logic [1:0] X_P    = 2'b10;
  localparam logic [1:0] X_DAB  = 2'b11;

  localparam logic [1:0] Z_ZERO = 2'b00;
  localparam logic [1:0] Z_PCIN = 2'b01;
  localparam logic [1:0] Z_P    = 2'b10;
  localparam logic [1:0] Z_C    = 2'b11;

  // Post-adder result: 48-bit sum plus carry/borrow out of bit 47.
  typedef struct packed {
    logic           co;
    logic [P_W-1:0] sum;
  } add_res_t;

endpackage

// File: rtl/dsp48a1_post_adder_if.sv
// Operand/result bundle between the M stage and the post-adder.
interface dsp48a1_post_adder_if;
  import dsp48a1_pkg::*;

  logic                  ce_p;
  logic                  ce_carry;
  logic [7:0]            opmode;
  logic signed [M_W-1:0] m_in;
  logic [P_W-1:0]        dab_in;
  logic [P_W-1:0]        c_in;
  logic [P_W-1:0]        pcin;
  logic                  cin;
  logic [P_W-1:0]        p;
  logic [P_W-1:0]        pcout;
  logic                  carryout;
  logic                  carryoutf;

  modport master (
    output ce_p, ce_carry, opmode, m_in, dab_in, c_in, pcin, cin,
    input  p, pcout, carryout, carryoutf
  );

  modport slave (
    input  ce_p, ce_carry, opmode, m_in, dab_in, c_in, pcin, cin,
    output p, pcout, carryout, carryoutf
  );

endinterface

// File: rtl/dsp48a1_xz_mux.sv
// X/Z operand selection for the post-adder, including M sign-extension.
module dsp48a1_xz_mux
  import dsp48a1_pkg::*;
(
  input  logic [1:0]            x_sel_i,
  input  logic [1:0]            z_sel_i,
  input  logic signed [M_W-1:0] m_i,
  input  logic [P_W-1:0]        dab_i,
  input  logic [P_W-1:0]        c_i,
  input  logic [P_W-1:0]        pcin_i,
  input  logic [P_W-1:0]        p_fb_i,
  output logic [P_W-1:0]        x_o,
  output logic [P_W-1:0]        z_o
);

  logic signed [P_W-1:0] m_ext_w;

  assign m_ext_w = {{(P_W-M_W){m_i[M_W-1]}}, m_i};

  // X operand select
  always_comb begin
    x_o = '0;
    case (x_sel_i)
      X_ZERO:  x_o = '0;
      X_M:     x_o = m_ext_w;
      X_P:     x_o = p_fb_i;
      X_DAB:   x_o = dab_i;
      default: x_o = '0;
    endcase
  end

  // Z operand select
  always_comb begin
    z_o = '0;
    case (z_sel_i)
      Z_ZERO:  z_o = '0;
      Z_PCIN:  z_o = pcin_i;
      Z_P:     z_o = p_fb_i;
      Z_C:     z_o = c_i;
      default: z_o = '0;
    endcase
  end

endmodule

// File: rtl/dsp48a1_post_adder.sv
// DSP48A1 post-adder/accumulator: X/Z select, add/sub with carry-in,
// optional P and CARRYOUT registers, P feedback and PCOUT cascade.
module dsp48a1_post_adder
  import dsp48a1_pkg::*;
#(
  parameter bit PREG        = 1'b1,
  parameter bit CARRYOUTREG = 1'b1
) (
  input logic                  clk,
  input logic                  rst,
  dsp48a1_post_adder_if.slave  bus
);

  logic [P_W-1:0] x_w;
  logic [P_W-1:0] z_w;
  logic [P_W-1:0] p_fb_w;
  logic [P_W-1:0] p_d;
  logic           co_d;
  logic [P_W-1:0] p_out_w;
  logic           co_out_w;
  add_res_t       res_w;
  logic           unused_opm_w;

  // 49-bit unsigned add/subtract; on subtract the top bit is the borrow.
  function automatic add_res_t post_add(input logic           sub_i,
                                        input logic [P_W-1:0] z_i,
                                        input logic [P_W-1:0] x_i,
                                        input logic           cin_i);
    logic [P_W:0] xc;
    logic [P_W:0] r;
    xc = {1'b0, x_i} + {{P_W{1'b0}}, cin_i};
    if (sub_i) r = {1'b0, z_i} - xc;
    else       r = {1'b0, z_i} + xc;
    post_add = add_res_t'(r);
  endfunction

  assign unused_opm_w = ^bus.opmode[6:4];

  dsp48a1_xz_mux u_xz_mux (
    .x_sel_i (bus.opmode[1:0]),
    .z_sel_i (bus.opmode[3:2]),
    .m_i     (bus.m_in),
    .dab_i   (bus.dab_in),
    .c_i     (bus.c_in),
    .pcin_i  (bus.pcin),
    .p_fb_i  (p_fb_w),
    .x_o     (x_w),
    .z_o     (z_w)
  );

  assign res_w = post_add(bus.opmode[OPM_SUB_BIT], z_w, x_w, bus.cin);
  assign p_d   = res_w.sum;
  assign co_d  = res_w.co;

  // ---- stage boundary: operands -> P / CARRYOUT ----
  generate
    if (PREG) begin : g_preg
      logic [P_W-1:0] p_q;

      // P register: reset dominates the clock enable
      always_ff @(posedge clk) begin
        if (rst)           p_q <= '0;
        else if (bus.ce_p) p_q <= p_d;
      end

      assign p_out_w = p_q;
      assign p_fb_w  = p_q;
    end else begin : g_pcomb
      assign p_out_w = p_d;
      assign p_fb_w  = '0;

      // Feedback has no source without the P register; flag its selection
      always @(posedge clk) begin
        if (!rst && (bus.opmode[1:0] == X_P || bus.opmode[3:2] == Z_P))
          $error("dsp48a1_post_adder: P feedback selected with PREG=0");
      end
    end

    if (CARRYOUTREG) begin : g_coreg
      logic co_q;

      // CARRYOUT register: may hold a stale value while P keeps updating
      always_ff @(posedge clk) begin
        if (rst)               co_q <= 1'b0;
        else if (bus.ce_carry) co_q <= co_d;
      end

      assign co_out_w = co_q;
    end else begin : g_cocomb
      assign co_out_w = co_d;
    end
  endgenerate

  assign bus.p         = p_out_w;
  assign bus.pcout     = p_out_w;
  assign bus.carryout  = co_out_w;
  assign bus.carryoutf = co_out_w;

endmodule

// File: tb/tb_dsp48a1_post_adder.sv
// Scoreboard bench for dsp48a1_post_adder: registered and combinational builds.
module tb_dsp48a1_post_adder;

  localparam logic [7:0] ADD_M    = 8'h01;  // Z=0,    X=M
  localparam logic [7:0] ACC_M    = 8'h09;  // Z=P,    X=M
  localparam logic [7:0] SUB_CD   = 8'h8F;  // Z=C  -  X=DAB
  localparam logic [7:0] ADD_CD   = 8'h0F;  // Z=C  +  X=DAB
  localparam logic [7:0] ADD_CM   = 8'h0D;  // Z=C  +  X=M
  localparam logic [7:0] ADD_PCIN = 8'h04;  // Z=PCIN, X=0
  localparam logic [7:0] ADD_PDAB = 8'h0B;  // Z=P  +  X=DAB
  localparam logic [7:0] ADD_CP   = 8'h0E;  // Z=C  +  X=P

  localparam logic [47:0] ONES = 48'hFFFF_FFFF_FFFF;
  localparam logic [35:0] M_NEG2 = 36'hF_FFFF_FFFE;

  typedef struct {
    int          due;
    logic [47:0] p;
    logic        co;
    string       nm;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_c = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  exp_t q_r[$];
  exp_t q_c[$];

  dsp48a1_post_adder_if ifr ();
  dsp48a1_post_adder_if ifc ();

  dsp48a1_post_adder #(.PREG(1'b1), .CARRYOUTREG(1'b1)) u_dut_reg (
    .clk (clk),
    .rst (rst),
    .bus (ifr.slave)
  );

  dsp48a1_post_adder #(.PREG(1'b0), .CARRYOUTREG(1'b0)) u_dut_comb (
    .clk (clk),
    .rst (rst_c),
    .bus (ifc.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp48(input string nm, input string fld, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s: got %h, expected %h (cycle %0d)", nm, fld, act, exp, cyc);
    end
  endtask

  task automatic cmp1(input string nm, input string fld, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s: got %b, expected %b (cycle %0d)", nm, fld, act, exp, cyc);
    end
  endtask

  // Monitor: pop every expectation due this cycle and compare all outputs
  always @(negedge clk) begin
    exp_t e;
    while (q_r.size() > 0 && q_r[0].due <= cyc) begin
      e = q_r.pop_front();
      cmp48({"reg.", e.nm}, "p", ifr.p, e.p);
      cmp48({"reg.", e.nm}, "pcout", ifr.pcout, e.p);
      cmp1({"reg.", e.nm}, "carryout", ifr.carryout, e.co);
      cmp1({"reg.", e.nm}, "carryoutf", ifr.carryoutf, e.co);
    end
    while (q_c.size() > 0 && q_c[0].due <= cyc) begin
      e = q_c.pop_front();
      cmp48({"comb.", e.nm}, "p", ifc.p, e.p);
      cmp48({"comb.", e.nm}, "pcout", ifc.pcout, e.p);
      cmp1({"comb.", e.nm}, "carryout", ifc.carryout, e.co);
      cmp1({"comb.", e.nm}, "carryoutf", ifc.carryoutf, e.co);
    end
  end

  task automatic rdrv(input logic r, input logic cep, input logic cec, input logic [7:0] opm,
                      input logic [35:0] m, input logic [47:0] dab, input logic [47:0] c,
                      input logic [47:0] pc, input logic ci);
    rst          = r;
    ifr.ce_p     = cep;
    ifr.ce_carry = cec;
    ifr.opmode   = opm;
    ifr.m_in     = m;
    ifr.dab_in   = dab;
    ifr.c_in     = c;
    ifr.pcin     = pc;
    ifr.cin      = ci;
  endtask

  // Registered build: result is visible after the next edge
  task automatic rexp(input logic [47:0] p, input logic co, input string nm);
    exp_t e;
    e.due = cyc + 1; e.p = p; e.co = co; e.nm = nm;
    q_r.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic cdrv(input logic cep, input logic [7:0] opm, input logic [35:0] m,
                      input logic [47:0] dab, input logic [47:0] c, input logic [47:0] pc,
                      input logic ci);
    ifc.ce_p     = cep;
    ifc.ce_carry = cep;
    ifc.opmode   = opm;
    ifc.m_in     = m;
    ifc.dab_in   = dab;
    ifc.c_in     = c;
    ifc.pcin     = pc;
    ifc.cin      = ci;
  endtask

  // Combinational build: result is visible in the same cycle
  task automatic cexp(input logic [47:0] p, input logic co, input string nm);
    exp_t e;
    e.due = cyc; e.p = p; e.co = co; e.nm = nm;
    q_c.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic run_reg();
    rdrv(1, 0, 0, ADD_M, 36'd5, '0, '0, '0, 0);      rexp(48'd0, 0, "reset");
    rdrv(1, 1, 1, ADD_M, 36'd5, '0, '0, '0, 0);      rexp(48'd0, 0, "reset_over_ce");
    rdrv(0, 1, 1, ADD_M, 36'd5, '0, '0, '0, 0);      rexp(48'd5, 0, "m5");
    rdrv(1, 1, 1, ACC_M, 36'd3, '0, '0, '0, 0);      rexp(48'd0, 0, "rst_pre_acc");
    for (int k = 1; k <= 3; k++) begin
      rdrv(0, 1, 1, ACC_M, 36'd3, '0, '0, '0, 0);    rexp(48'(3 * k), 0, "acc");
    end
    rdrv(1, 1, 1, ACC_M, 36'd3, '0, '0, '0, 0);      rexp(48'd0, 0, "rst_mid_acc");
    rdrv(0, 1, 1, ACC_M, 36'd3, '0, '0, '0, 0);      rexp(48'd3, 0, "acc_restart1");
                                                     rexp(48'd6, 0, "acc_restart2");
                                                     rexp(48'd9, 0, "acc_restart3");
                                                     rexp(48'd12, 0, "acc_restart4");
    rdrv(0, 1, 1, SUB_CD, '0, 48'd3, 48'd10, '0, 1); rexp(48'd6, 0, "sub_10_3_1");
    rdrv(0, 1, 1, SUB_CD, '0, 48'd3, 48'd2, '0, 1);  rexp(48'hFFFF_FFFF_FFFE, 1, "sub_borrow");
    rdrv(0, 1, 1, ADD_CD, '0, 48'd1, ONES, '0, 0);   rexp(48'd0, 1, "wrap");
    rdrv(0, 0, 0, ADD_CD, '0, 48'd1, 48'd100, '0, 0); rexp(48'd0, 1, "hold_ce0");
    rdrv(0, 1, 0, ADD_CD, '0, 48'd1, 48'd7, '0, 0);  rexp(48'd8, 1, "stale_carry");
    rdrv(0, 1, 1, ADD_CD, '0, 48'd1, 48'd7, '0, 0);  rexp(48'd8, 0, "carry_update");
    rdrv(0, 1, 1, ADD_M, M_NEG2, '0, '0, '0, 0);     rexp(48'hFFFF_FFFF_FFFE, 0, "m_sext");
    rdrv(0, 1, 1, ADD_CM, M_NEG2, '0, 48'd5, '0, 0); rexp(48'd3, 1, "c_plus_mneg");
    rdrv(0, 1, 1, ADD_PCIN, '0, '0, '0, 48'h1234_5678_9ABC, 1);
                                                     rexp(48'h1234_5678_9ABD, 0, "pcin_cin");
    rdrv(0, 1, 1, ADD_PDAB, '0, 48'd2, '0, '0, 0);   rexp(48'h1234_5678_9ABF, 0, "zp_fb");
    rdrv(0, 1, 1, ADD_CP, '0, '0, 48'd1, '0, 0);     rexp(48'h1234_5678_9AC0, 0, "xp_fb");
    rdrv(0, 0, 0, ADD_M, '0, '0, '0, '0, 0);
  endtask

  task automatic run_comb();
    cdrv(1, ADD_M, 36'd5, '0, '0, '0, 0);            cexp(48'd5, 0, "m5");
    cdrv(1, ADD_M, 36'd5, '0, '0, '0, 1);            cexp(48'd6, 0, "m5_cin");
    cdrv(0, ADD_CD, '0, 48'd1, ONES, '0, 0);         cexp(48'd0, 1, "wrap_ce0");
    cdrv(1, SUB_CD, '0, 48'd3, 48'd2, '0, 1);        cexp(48'hFFFF_FFFF_FFFE, 1, "sub_borrow");
    cdrv(1, SUB_CD, '0, 48'd3, 48'd10, '0, 1);       cexp(48'd6, 0, "sub_10_3_1");
    cdrv(1, ADD_PCIN, '0, '0, '0, 48'h1234_5678_9ABC, 0);
                                                     cexp(48'h1234_5678_9ABC, 0, "pcin");
    cdrv(1, ADD_CM, M_NEG2, '0, 48'd5, '0, 0);       cexp(48'd3, 1, "c_plus_mneg");
    cdrv(0, ADD_M, '0, '0, '0, '0, 0);
  endtask

  initial begin
    rdrv(1, 0, 0, 8'h00, '0, '0, '0, '0, 0);
    cdrv(0, 8'h00, '0, '0, '0, '0, 0);
    @(posedge clk); #1;
    fork
      run_reg();
      run_comb();
    join
    repeat (3) begin
      @(posedge clk); #1;
    end
    checks++;
    if (q_r.size() + q_c.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q_r.size() + q_c.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
